// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one synchronous BRAM port. Requester 1 wins conflicts
// unless requester 0 has been denied STARVE_LIMIT times in a row; responses return one cycle later.
module bram_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic                  i_req0_write,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  input  logic                  i_req1_write,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  output logic                  o_bram_write,
  input  logic [DATA_WIDTH-1:0] i_bram_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a request transfers on the rising edge where its valid and ready
  // are both 1. Ready depends only on the valids and the starvation counter.
  logic [3:0] starve_cnt;
  logic       grant0;
  logic       grant1;
  logic       owner_valid;
  logic       owner_id;

  // Grants are gated by reset so both readies read 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_rst_n) begin
      if (i_req0_valid && (!i_req1_valid || (starve_cnt >= LIMIT))) begin
        grant0 = 1'b1;
      end else if (i_req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    o_bram_addr  = '0;
    o_bram_data  = '0;
    o_bram_write = 1'b0;
    if (grant0) begin
      o_bram_addr  = i_req0_addr;
      o_bram_data  = i_req0_wdata;
      o_bram_write = i_req0_write;
    end else if (grant1) begin
      o_bram_addr  = i_req1_addr;
      o_bram_data  = i_req1_wdata;
      o_bram_write = i_req1_write;
    end
  end

  // Counter saturates at LIMIT; a dropped req0 valid leaves it untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= 4'd0;
    end else if (grant0) begin
      starve_cnt <= 4'd0;
    end else if (i_req0_valid && (starve_cnt < LIMIT)) begin
      starve_cnt <= 4'(starve_cnt + 4'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_valid <= 1'b0;
      owner_id    <= 1'b0;
    end else begin
      owner_valid <= grant0 | grant1;
      owner_id    <= grant1;
    end
  end

  assign o_rsp0_valid = owner_valid & ~owner_id;
  assign o_rsp1_valid = owner_valid &  owner_id;
  assign o_rsp0_data  = o_rsp0_valid ? i_bram_data : '0;
  assign o_rsp1_data  = o_rsp1_valid ? i_bram_data : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a write-through BRAM model behind the
// default instance, plus a second instance with STARVE_LIMIT=0.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        preload;

  logic        req0_valid, req0_ready, req0_write, rsp0_valid;
  logic [9:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_data;
  logic        req1_valid, req1_ready, req1_write, rsp1_valid;
  logic [9:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_data;
  logic [9:0]  bram_addr;
  logic [31:0] bram_data, bram_q;
  logic        bram_write;
  logic [31:0] mem [1024];

  // Second instance, STARVE_LIMIT=0
  logic        z_req0_valid, z_req0_ready, z_rsp0_valid;
  logic        z_req1_valid, z_req1_ready, z_rsp1_valid;
  logic [31:0] z_rsp0_data, z_rsp1_data, z_bram_data;
  logic [9:0]  z_bram_addr;
  logic        z_bram_write;
  logic [31:0] z_bram_q;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .STARVE_LIMIT(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .i_req0_write(req0_write),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_data(rsp0_data),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .i_req1_write(req1_write),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_data(rsp1_data),
    .o_bram_addr(bram_addr), .o_bram_data(bram_data), .o_bram_write(bram_write),
    .i_bram_data(bram_q)
  );

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .STARVE_LIMIT(0)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(z_req0_valid), .o_req0_ready(z_req0_ready), .i_req0_addr(10'h001),
    .i_req0_wdata(32'h0), .i_req0_write(1'b0),
    .o_rsp0_valid(z_rsp0_valid), .o_rsp0_data(z_rsp0_data),
    .i_req1_valid(z_req1_valid), .o_req1_ready(z_req1_ready), .i_req1_addr(10'h002),
    .i_req1_wdata(32'h0), .i_req1_write(1'b0),
    .o_rsp1_valid(z_rsp1_valid), .o_rsp1_data(z_rsp1_data),
    .o_bram_addr(z_bram_addr), .o_bram_data(z_bram_data), .o_bram_write(z_bram_write),
    .i_bram_data(z_bram_q)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-through synchronous BRAM model
  always @(posedge clk) begin
    if (preload) begin
      mem[5] <= 32'hDEADBEEF;
    end else if (bram_write) begin
      mem[bram_addr] <= bram_data;
      bram_q         <= bram_data;
    end else begin
      bram_q <= mem[bram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [9:0] a, input logic [31:0] d, input logic w);
    req0_valid = v; req0_addr = a; req0_wdata = d; req0_write = w;
  endtask

  task automatic drive1(input logic v, input logic [9:0] a, input logic [31:0] d, input logic w);
    req1_valid = v; req1_addr = a; req1_wdata = d; req1_write = w;
  endtask

  int exp_cnt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_gnt [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0;
    preload = 1'b1;
    bram_q = 32'h0;
    z_bram_q = 32'h0;
    z_req0_valid = 1'b0;
    z_req1_valid = 1'b0;
    drive0(1'b1, 10'h001, 32'h0, 1'b0);
    drive1(1'b1, 10'h002, 32'h0, 1'b0);

    // Reset with both valids high
    repeat (3) step();
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_bram_write", 32'(bram_write), 0);
    check("rst_bram_addr", 32'(bram_addr), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_cnt", 32'(dut.starve_cnt), 0);

    // Release; req1 reads preloaded 0x005 on the first cycle
    rst_n = 1'b1;
    preload = 1'b0;
    drive0(1'b0, 10'h0, 32'h0, 1'b0);
    drive1(1'b1, 10'h005, 32'h0, 1'b0);
    #1;
    check("rd_ready1", 32'(req1_ready), 1);
    check("rd_ready0", 32'(req0_ready), 0);
    check("rd_bram_addr", 32'(bram_addr), 32'h005);
    step();
    check("rd_rsp1_valid", 32'(rsp1_valid), 1);
    check("rd_rsp1_data", rsp1_data, 32'hDEADBEEF);
    check("rd_rsp0_valid", 32'(rsp0_valid), 0);
    check("rd_rsp0_data", rsp0_data, 0);
    drive1(1'b0, 10'h0, 32'h0, 1'b0);
    #1;
    check("idle_bram_addr", 32'(bram_addr), 0);
    step();
    check("idle_rsp1_valid", 32'(rsp1_valid), 0);

    // Starvation with both valid for 8 cycles
    drive0(1'b1, 10'h001, 32'h0, 1'b0);
    drive1(1'b1, 10'h002, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("stv_cnt_%0d", i), 32'(dut.starve_cnt), exp_cnt[i]);
      check($sformatf("stv_ready0_%0d", i), 32'(req0_ready), (exp_gnt[i] == 0) ? 1 : 0);
      check($sformatf("stv_ready1_%0d", i), 32'(req1_ready), exp_gnt[i]);
      check($sformatf("stv_addr_%0d", i), 32'(bram_addr), (exp_gnt[i] == 0) ? 1 : 2);
      step();
      check($sformatf("stv_rsp0_%0d", i), 32'(rsp0_valid), (exp_gnt[i] == 0) ? 1 : 0);
      check($sformatf("stv_rsp1_%0d", i), 32'(rsp1_valid), exp_gnt[i]);
    end
    check("stv_cnt_after", 32'(dut.starve_cnt), 0);

    // req1 writes 0x010, then req0 reads it back
    drive0(1'b0, 10'h0, 32'h0, 1'b0);
    drive1(1'b1, 10'h010, 32'h12345678, 1'b1);
    #1;
    check("wr_ready1", 32'(req1_ready), 1);
    check("wr_bram_write", 32'(bram_write), 1);
    check("wr_bram_data", bram_data, 32'h12345678);
    step();
    check("wr_rsp1_valid", 32'(rsp1_valid), 1);
    check("wr_rsp1_data", rsp1_data, 32'h12345678);
    drive1(1'b0, 10'h0, 32'h0, 1'b0);
    drive0(1'b1, 10'h010, 32'h0, 1'b0);
    #1;
    check("fw_ready0", 32'(req0_ready), 1);
    check("fw_bram_write", 32'(bram_write), 0);
    step();
    check("fw_rsp0_valid", 32'(rsp0_valid), 1);
    check("fw_rsp0_data", rsp0_data, 32'h12345678);
    check("fw_rsp1_data", rsp1_data, 0);

    // Counter holds while req0 drops valid, then resumes toward the forced grant
    drive0(1'b1, 10'h001, 32'h0, 1'b0);
    drive1(1'b1, 10'h002, 32'h0, 1'b0);
    repeat (2) step();
    drive0(1'b0, 10'h0, 32'h0, 1'b0);
    step();
    check("hold_cnt_a", 32'(dut.starve_cnt), 2);
    drive1(1'b0, 10'h0, 32'h0, 1'b0);
    step();
    check("hold_cnt_b", 32'(dut.starve_cnt), 2);
    drive0(1'b1, 10'h001, 32'h0, 1'b0);
    drive1(1'b1, 10'h002, 32'h0, 1'b0);
    #1;
    check("hold_ready1", 32'(req1_ready), 1);
    step();
    check("hold_ready0", 32'(req0_ready), 1);
    check("hold_cnt_c", 32'(dut.starve_cnt), 3);
    step();
    check("hold_cnt_d", 32'(dut.starve_cnt), 0);

    // Reset while a req0 response is in flight
    drive1(1'b0, 10'h0, 32'h0, 1'b0);
    drive0(1'b1, 10'h005, 32'h0, 1'b0);
    #1;
    check("mfr_ready0", 32'(req0_ready), 1);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    drive0(1'b0, 10'h0, 32'h0, 1'b0);
    check("mfr_rsp0_in_reset", 32'(rsp0_valid), 0);
    step();
    check("mfr_rsp0_held", 32'(rsp0_valid), 0);
    rst_n = 1'b1;
    step();
    check("mfr_rsp0_after", 32'(rsp0_valid), 0);
    check("mfr_rsp1_after", 32'(rsp1_valid), 0);
    step();
    check("mfr_rsp0_after2", 32'(rsp0_valid), 0);

    // STARVE_LIMIT=0: req0 wins every conflict
    z_req0_valid = 1'b1;
    z_req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("z_ready0_%0d", i), 32'(z_req0_ready), 1);
      check($sformatf("z_ready1_%0d", i), 32'(z_req1_ready), 0);
      check($sformatf("z_addr_%0d", i), 32'(z_bram_addr), 1);
      step();
      check($sformatf("z_rsp1_%0d", i), 32'(z_rsp1_valid), 0);
    end
    z_req0_valid = 1'b0;
    z_req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one synchronous BRAM port between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store).
- Requester 1 wins conflicts by default. A starvation counter forces a grant to requester 0 after STARVE_LIMIT consecutive denials.
- Each request takes one BRAM port for one cycle. Its response returns exactly one cycle later and is routed back to the issuing requester.
- Sits between the CPU pipeline front-ends and one port of the dual-port BRAM. The other BRAM port stays free for DMA/debug.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH, 10, BRAM word address width.
- STARVE_LIMIT, 3, consecutive denials of requester 0 (while it is valid) that force its next grant. Range 0..15; 0 means requester 0 always wins.

Ports:
- i_clk  in  1  clock; the BRAM port is clocked from the same net.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req0_valid  in  1  requester 0 request.
- o_req0_ready  out  1  requester 0 accepted this cycle (combinational).
- i_req0_addr  in  ADDR_WIDTH  requester 0 address.
- i_req0_wdata  in  DATA_WIDTH  requester 0 write data.
- i_req0_write  in  1  1=write, 0=read.
- o_rsp0_valid  out  1  response for requester 0 (registered pulse).
- o_rsp0_data  out  DATA_WIDTH  read data, or written data for writes.
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_wdata, i_req1_write, o_rsp1_valid, o_rsp1_data: same as requester 0, for requester 1.
- o_bram_addr  out  ADDR_WIDTH  to BRAM address.
- o_bram_data  out  DATA_WIDTH  to BRAM write data.
- o_bram_write  out  1  to BRAM write enable.
- i_bram_data  in  DATA_WIDTH  from BRAM registered output.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is asynchronous, active-low, on i_rst_n.
  - While i_rst_n=0: both readies 0, o_bram_write 0, o_bram_addr 0, o_bram_data 0, o_rsp0_valid 0, o_rsp1_valid 0, starvation counter 0, in-flight owner cleared.
- Handshake:
  - A request transfers in cycle T iff valid and ready are both 1 at the rising edge ending T.
  - Readies are combinational from the valids and the counter; they have no dependency on any other ready.
  - Requesters hold addr/wdata/write stable while valid is high and ready is low.
- Grant, evaluated each cycle:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant 0 if starve_cnt >= STARVE_LIMIT, else grant 1.
  - Neither valid: no grant.
  - At most one ready is high per cycle.
- BRAM drive, combinational:
  - On a grant: o_bram_addr, o_bram_data and o_bram_write come from the granted requester.
  - With no grant: addr 0, data 0, write 0.
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - Cleared on the edge where req0 is accepted.
  - Incremented on the edge where req0 is valid and not granted.
  - Unchanged otherwise.
- Response path:
  - Owner register: 2 bits, {valid, id}, set at each accepting edge and cleared when there is no grant.
  - In cycle T+1 after acceptance in T: o_rspN_valid=1 for the owner only.
  - o_rspN_data = i_bram_data (BRAM is write-through, so writes return wdata).
  - Latency is exactly 1 cycle. There is no response backpressure; requesters always sink responses.
  - The non-owner's rsp_data output is 0.
- Throughput:
  - One transfer per cycle.
  - Back-to-back grants to different requesters are legal; responses interleave in grant order.
- Boundaries:
  - Same-address write then read from different requesters on consecutive cycles: the read returns the new data (the BRAM write lands at the edge ending the write cycle).
  - Reset asserted while a response is in flight: the response is dropped, with no rsp_valid after reset release.
  - Requester 0 dropping valid before being granted: the counter holds. Requesters must not drop valid, but if they do the counter still holds.

Test Plan:
- Reset: hold i_rst_n=0 with both valids 1 -> both readies 0, o_bram_write 0, no rsp pulses. Release -> first grant on the next cycle.
- Single read: req1 reads addr 0x005 (BRAM preloaded 0xDEADBEEF) -> o_req1_ready=1 in T, o_rsp1_valid=1 with data 0xDEADBEEF in T+1, o_rsp0_valid=0.
- Starvation, STARVE_LIMIT=3: both valid continuously for 8 cycles -> grant sequence 1,1,1,0,1,1,1,0. Counter reads 0,1,2,3,0,1,2,3.
- Write/read forwarding: req1 writes 0x12345678 to 0x010 in T; req0 reads 0x010 in T+1 -> o_rsp1_data=0x12345678 in T+1, o_rsp0_data=0x12345678 in T+2.
- STARVE_LIMIT=0: both valid for 4 cycles -> req0 granted every cycle, req1 never granted.
- Mid-flight reset: req0 read accepted in T; i_rst_n low during T+1 -> o_rsp0_valid stays 0 throughout and after release.
